// File: rtl/stream_frame_gen.sv
// stream_frame_gen: frames an unframed stream of full-width words into
// beats carrying tlast/tkeep for a run-time byte length.
//
// Ports:
//   clock, reset_n           rising-edge clock, async active-low reset
//   start, length, abort     frame request, byte length, synchronous cancel
//   busy, done, error_len    frame in progress, completion pulse, zero-length pulse
//   in_data/in_valid/in_ready         unframed input stream (in_ready registered)
//   out_data/out_keep/out_last/
//   out_valid/out_ready               framed output stream (LSB-aligned keep)
module stream_frame_gen #(
    parameter int unsigned DATA_BYTES = 16,
    parameter int unsigned LEN_BITS   = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [LEN_BITS-1:0]     length,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    error_len,
    input  logic [DATA_BYTES*8-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_BYTES*8-1:0] out_data,
    output logic [DATA_BYTES-1:0]   out_keep,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int unsigned         DATA_W     = DATA_BYTES * 8;
    localparam logic [LEN_BITS-1:0] WORD_BYTES = LEN_BITS'(DATA_BYTES);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]            state, state_nx;
    logic [LEN_BITS-1:0]   remaining, remaining_nx;

    logic                  busy_nx, done_nx, error_len_nx, in_ready_nx;
    logic [DATA_W-1:0]     out_data_nx;
    logic [DATA_BYTES-1:0] out_keep_nx;
    logic                  out_last_nx, out_valid_nx;

    logic                  skid_valid, skid_valid_nx;
    logic [DATA_W-1:0]     skid_data, skid_data_nx;
    logic [DATA_BYTES-1:0] skid_keep, skid_keep_nx;
    logic                  skid_last, skid_last_nx;

    logic                  in_fire, out_fire, tail;
    logic [4:0]            rem_lo;
    logic [DATA_W-1:0]     beat_data;
    logic [DATA_BYTES-1:0] beat_keep;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign rem_lo   = remaining[4:0];

    // Beat built from the current input word; the final beat keeps only
    // the low 'remaining' bytes and zeroes the rest.
    always_comb begin
        tail      = (remaining <= WORD_BYTES);
        beat_keep = '0;
        beat_data = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            beat_keep[i]         = tail ? (5'(i) < rem_lo) : 1'b1;
            beat_data[i*8 +: 8]  = beat_keep[i] ? in_data[i*8 +: 8] : 8'h00;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_nx      = state;
        remaining_nx  = remaining;
        done_nx       = 1'b0;
        error_len_nx  = 1'b0;
        out_data_nx   = out_data;
        out_keep_nx   = out_keep;
        out_last_nx   = out_last;
        out_valid_nx  = out_valid;
        skid_valid_nx = skid_valid;
        skid_data_nx  = skid_data;
        skid_keep_nx  = skid_keep;
        skid_last_nx  = skid_last;

        // Output register drains; the skid entry (if any) moves up.
        if (out_fire) begin
            out_valid_nx  = skid_valid;
            skid_valid_nx = 1'b0;
            if (skid_valid) begin
                out_data_nx = skid_data;
                out_keep_nx = skid_keep;
                out_last_nx = skid_last;
            end
        end

        // in_ready implies an empty skid, so a new beat always has a home.
        if (in_fire) begin
            remaining_nx = tail ? '0 : remaining - WORD_BYTES;
            if (!out_valid_nx) begin
                out_valid_nx = 1'b1;
                out_data_nx  = beat_data;
                out_keep_nx  = beat_keep;
                out_last_nx  = tail;
            end else begin
                skid_valid_nx = 1'b1;
                skid_data_nx  = beat_data;
                skid_keep_nx  = beat_keep;
                skid_last_nx  = tail;
            end
        end

        case (state)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        error_len_nx = 1'b1;
                    end else begin
                        remaining_nx = length;
                        state_nx     = RUN;
                    end
                end
            end
            RUN: begin
                if (in_fire && tail) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid_nx && !skid_valid_nx) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Abort overrides everything, including a coincident start.
        if (abort) begin
            state_nx      = IDLE;
            remaining_nx  = '0;
            done_nx       = 1'b0;
            error_len_nx  = 1'b0;
            out_valid_nx  = 1'b0;
            out_last_nx   = 1'b0;
            out_keep_nx   = '0;
            out_data_nx   = '0;
            skid_valid_nx = 1'b0;
        end

        busy_nx     = (state_nx != IDLE);
        in_ready_nx = (state_nx == RUN) && !skid_valid_nx;
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            remaining  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error_len  <= 1'b0;
            in_ready   <= 1'b0;
            out_data   <= '0;
            out_keep   <= '0;
            out_last   <= 1'b0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_keep  <= '0;
            skid_last  <= 1'b0;
        end else begin
            state      <= state_nx;
            remaining  <= remaining_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            error_len  <= error_len_nx;
            in_ready   <= in_ready_nx;
            out_data   <= out_data_nx;
            out_keep   <= out_keep_nx;
            out_last   <= out_last_nx;
            out_valid  <= out_valid_nx;
            skid_valid <= skid_valid_nx;
            skid_data  <= skid_data_nx;
            skid_keep  <= skid_keep_nx;
            skid_last  <= skid_last_nx;
        end
    end

endmodule

// File: tb/tb_stream_frame_gen.sv
// tb_stream_frame_gen: directed bench for stream_frame_gen with a frame-level
// expected-beat model and a per-cycle compare process.
module tb_stream_frame_gen;

    localparam int DB = 16;
    localparam int DW = 128;
    localparam int LB = 32;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [DB-1:0] k;
        logic          l;
    } beat_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic [LB-1:0] length;
    logic          abort;
    logic          busy, done, error_len;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [DB-1:0] out_keep;
    logic          out_last, out_valid;
    logic          out_ready;

    stream_frame_gen #(.DATA_BYTES(DB), .LEN_BITS(LB)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .length(length),
        .abort(abort), .busy(busy), .done(done), .error_len(error_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected beat for one accepted input word, given bytes still owed.
    function automatic beat_t model_beat(input logic [DW-1:0] w, input logic [LB-1:0] rem);
        beat_t b;
        logic [DB:0] m;
        b.d = w;
        if (rem > 32'd16) begin
            b.k = 16'hffff;
            b.l = 1'b0;
        end else begin
            m   = (17'd1 << rem) - 17'd1;
            b.k = m[DB-1:0];
            b.l = 1'b1;
            for (int i = 0; i < DB; i++)
                if (!b.k[i]) b.d[i*8 +: 8] = 8'h00;
        end
        return b;
    endfunction

    beat_t         exp_q[$];
    logic [LB-1:0] model_rem = '0;
    bit            model_en = 1'b0;
    bit            flush_ok = 1'b0;
    bit            rand_rdy = 1'b0;
    bit            hold_rdy = 1'b1;

    int            cyc = 0;
    int            beat_cnt = 0, last_cnt = 0, done_cnt = 0;
    int            first_hs = -1, last_hs = -1, done_cyc = -1;
    logic [DB-1:0] last_keep = '0;

    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [DB-1:0] prev_keep;
    logic          prev_last;

    always @(posedge clock) cyc++;

    // out_ready driver; updates after the main stimulus settles each cycle.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : hold_rdy;
        end
    end

    // Compare process: output beats vs. model, AXI stability, event logging.
    always @(negedge clock) begin
        beat_t b;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_stall && !flush_ok) begin
                chk("stall_valid", DW'(out_valid), DW'(1));
                chk("stall_data", out_data, prev_data);
                chk("stall_keep", DW'(out_keep), DW'(prev_keep));
                chk("stall_last", DW'(out_last), DW'(prev_last));
            end
            if (out_valid && out_ready) begin
                chk("beat_expected", DW'(exp_q.size() != 0), DW'(1));
                if (exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    chk("beat_data", out_data, b.d);
                    chk("beat_keep", DW'(out_keep), DW'(b.k));
                    chk("beat_last", DW'(out_last), DW'(b.l));
                end
                if (beat_cnt == 0) first_hs = cyc;
                beat_cnt++;
                last_hs = cyc;
                if (out_last) begin
                    last_cnt++;
                    last_keep = out_keep;
                end
            end
            if (model_en && in_valid && in_ready) begin
                exp_q.push_back(model_beat(in_data, model_rem));
                model_rem = (model_rem > 32'd16) ? model_rem - 32'd16 : '0;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_keep  = out_keep;
            prev_last  = out_last;
        end
    end

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Runs one frame of nwords input words and checks beat count, tlast and
    // final keep against hand-computed values.
    task automatic send_frame(input logic [LB-1:0] len, input int nwords, input bit rand_in,
                              input bit mid_start, input int exp_beats, input logic [DB-1:0] exp_keep);
        int  d0;
        int  n;
        bit  fired;
        beat_cnt = 0; last_cnt = 0; first_hs = -1; last_hs = -1; last_keep = '0;
        d0 = done_cnt;
        @(posedge clock); #1;
        start = 1'b1; length = len; model_rem = len; model_en = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < nwords; i++) begin
            in_data = rand_word();
            fired = 1'b0;
            n = 0;
            while (!fired && n < 200) begin
                in_valid = rand_in ? ($urandom_range(0, 2) != 0) : 1'b1;
                start    = mid_start && (i == 1) && (n == 0);
                length   = start ? 32'd5 : len;
                @(negedge clock);
                fired = in_valid && in_ready;
                n++;
                @(posedge clock); #1;
            end
            chk("in_accept", DW'(fired), DW'(1));
        end
        start = 1'b0;
        in_valid = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk("done_count", DW'(done_cnt - d0), DW'(1));
        chk("beats", DW'(beat_cnt), DW'(exp_beats));
        chk("last_count", DW'(last_cnt), DW'(1));
        chk("last_keep", DW'(last_keep), DW'(exp_keep));
        chk("done_latency", DW'(done_cyc - last_hs), DW'(1));
        chk("queue_empty", DW'(exp_q.size()), DW'(0));
        chk("busy_after", DW'(busy), DW'(0));
        model_en = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, DW'(busy), DW'(0));
        chk({tag, "_done"}, DW'(done), DW'(0));
        chk({tag, "_error_len"}, DW'(error_len), DW'(0));
        chk({tag, "_in_ready"}, DW'(in_ready), DW'(0));
        chk({tag, "_out_valid"}, DW'(out_valid), DW'(0));
        chk({tag, "_out_last"}, DW'(out_last), DW'(0));
        chk({tag, "_out_keep"}, DW'(out_keep), DW'(0));
        chk({tag, "_out_data"}, out_data, DW'(0));
    endtask

    // Pins the model itself against hand-computed beats.
    task automatic pin_model();
        beat_t b;
        logic [DW-1:0] w;
        w = {DB{8'hA5}};
        b = model_beat(w, 32'd8);
        chk("model_keep_8", DW'(b.k), DW'(16'h00ff));
        chk("model_data_8", b.d, {{8{8'h00}}, {8{8'hA5}}});
        b = model_beat(w, 32'd1);
        chk("model_keep_1", DW'(b.k), DW'(16'h0001));
        b = model_beat(w, 32'd16);
        chk("model_keep_16", DW'(b.k), DW'(16'hffff));
        chk("model_last_16", DW'(b.l), DW'(1));
        b = model_beat(w, 32'd17);
        chk("model_last_17", DW'(b.l), DW'(0));
    endtask

    // Feeds two words of a 64-byte frame back to back.
    task automatic start_two_words();
        @(posedge clock); #1;
        start = 1'b1; length = 32'd64; model_rem = 32'd64; model_en = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        in_data = rand_word(); in_valid = 1'b1;
        @(posedge clock); #1;
        in_data = rand_word();
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; length = '0; abort = 1'b0;
        in_data = '0; in_valid = 1'b0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;

        pin_model();

        // 40 bytes, full throughput: 3 back-to-back beats, done one cycle later.
        send_frame(32'd40, 3, 1'b0, 1'b0, 3, 16'h00ff);
        chk("len40_no_gaps", DW'(last_hs - first_hs), DW'(2));

        send_frame(32'd16, 1, 1'b0, 1'b0, 1, 16'hffff);
        send_frame(32'd1, 1, 1'b0, 1'b0, 1, 16'h0001);

        // Zero-length request.
        @(posedge clock); #1;
        start = 1'b1; length = 32'd0;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        chk("err_pulse", DW'(error_len), DW'(1));
        chk("err_in_ready", DW'(in_ready), DW'(0));
        chk("err_busy", DW'(busy), DW'(0));
        chk("err_out_valid", DW'(out_valid), DW'(0));
        @(negedge clock);
        chk("err_one_cycle", DW'(error_len), DW'(0));
        chk("err_busy2", DW'(busy), DW'(0));

        // Long frame with random stalls on both sides.
        rand_rdy = 1'b1;
        send_frame(32'd1000, 63, 1'b1, 1'b0, 63, 16'h00ff);
        rand_rdy = 1'b0;
        repeat (2) @(posedge clock);

        // start during RUN is ignored.
        send_frame(32'd40, 3, 1'b0, 1'b1, 3, 16'h00ff);

        // Abort at beat 2 of 4.
        hold_rdy = 1'b1;
        done_cyc = -1;
        start_two_words();
        abort = 1'b1; flush_ok = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        @(negedge clock);
        chk("abort_out_valid", DW'(out_valid), DW'(0));
        chk("abort_busy", DW'(busy), DW'(0));
        chk("abort_in_ready", DW'(in_ready), DW'(0));
        chk("abort_done", DW'(done), DW'(0));
        repeat (3) begin
            @(negedge clock);
            chk("abort_no_done", DW'(done), DW'(0));
        end
        exp_q.delete();
        model_en = 1'b0;
        flush_ok = 1'b0;

        // Reset mid-frame with a stalled beat pending.
        hold_rdy = 1'b0;
        start_two_words();
        @(negedge clock);
        chk("pre_reset_valid", DW'(out_valid), DW'(1));
        #2;
        reset_n = 1'b0; flush_ok = 1'b1;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        model_en = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        hold_rdy = 1'b1;
        repeat (2) @(posedge clock);
        flush_ok = 1'b0;

        // Clean frame after reset.
        send_frame(32'd32, 2, 1'b0, 1'b0, 2, 16'hffff);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_frame_gen.md
# stream_frame_gen

Source-side framer that turns an unframed AXI-stream of full-width words into a framed stream with `tlast`/`tkeep`, for a run-time byte length. It sits upstream of the width converters and the DMA TX path, which consume LSB-aligned `tkeep` and a single `tlast` per frame. It supports one frame per `start`, sustains full throughput, and reports zero-length requests as an error.

## Interface
- `DATA_BYTES`, 16: bytes per word, 1..16.
- `LEN_BITS`, 32: width of the `length` port and the remaining-byte counter.
- `clock` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset; all state returns to reset values immediately.
- `start` input 1: one-cycle request to begin a frame; sampled only in IDLE.
- `length` input LEN_BITS: frame length in bytes, latched on accepted `start`.
- `abort` input 1: synchronous frame cancel.
- `busy` output 1: high while a frame is in progress.
- `done` output 1: one-cycle pulse at frame completion.
- `error_len` output 1: one-cycle pulse when `start` arrives with `length`==0.
- `in_data` input DATA_BYTES*8: unframed input word.
- `in_valid` input 1: input word valid.
- `in_ready` output 1: registered input ready.
- `out_data` output DATA_BYTES*8: framed output word; bytes not kept are zero.
- `out_keep` output DATA_BYTES: LSB-aligned byte enables.
- `out_last` output 1: set on the final beat of the frame.
- `out_valid` output 1: output word valid.
- `out_ready` input 1: downstream ready.

## Operation
- State machine states: IDLE, RUN, DRAIN.
- **IDLE**
  - `in_ready`=0 and `busy`=0.
  - `start` with `length`>0: latch `remaining`=`length`, go to RUN.
  - `start` with `length`==0: pulse `error_len` and stay in IDLE.
- **RUN**
  - Each input handshake (`in_valid`&`in_ready`) produces one output word.
  - If `remaining` > DATA_BYTES: `out_keep` is all ones, `out_last`=0, and `remaining` -= DATA_BYTES.
  - Otherwise: `out_keep` = (1<<`remaining`)-1, bytes at index ≥`remaining` are forced to 0, `out_last`=1, `remaining`=0, and the state goes to DRAIN.
  - `in_ready` drops the cycle after the last input handshake.
- **DRAIN**
  - No input is accepted.
  - When the output stage and skid entry are both empty (last beat handshaken), pulse `done`, clear `busy`, and go to IDLE.
- `start` in RUN or DRAIN is ignored. It is not queued and produces no error.
- `abort` in any state:
  - the next cycle is IDLE, the output stage and skid are flushed (`out_valid`=0), and `remaining`=0;
  - `done` is not pulsed, and frame data already handshaken downstream is not recalled.
- Arithmetic: the `remaining` compare and subtract are unsigned at LEN_BITS. The keep mask is derived from `remaining`[4:0] only when 1 ≤ `remaining` ≤ DATA_BYTES.
- Frame length in beats = ceil(`length`/DATA_BYTES). The maximum `length` is 2^LEN_BITS-1.

## Timing
- Reset values:
  - `in_ready`, `out_valid`, `out_last`, `busy`, `done`, `error_len` = 0;
  - `out_data` and `out_keep` = 0;
  - state = IDLE, `remaining` = 0.
- The `start` → `in_ready` high latency is 1 cycle. `busy` rises on the same edge.
- The input-handshake → `out_valid` latency is 1 cycle, because the output is registered.
- Datapath buffering: one output register plus a one-entry skid buffer.
  - `in_ready` is registered, and is high in RUN when the skid entry is empty.
  - With `out_ready` held high, throughput is 1 word per cycle with no gaps.
- AXI rule: while `out_valid` & ~`out_ready`, `out_data`, `out_keep` and `out_last` are held stable. `out_valid` never drops without a handshake except on `abort` or reset.
- `done` asserts the cycle after the `out_last` handshake. `busy` falls on that same edge.
- When the frame's final beat fills the skid, the first post-frame `start` is accepted only once the frame is back in IDLE.
- Simultaneous `start` and `abort` in IDLE: `abort` wins and no frame starts.
- Reset asserted mid-frame: all outputs go to reset values asynchronously, and any partial frame is discarded.

## Test plan
- DATA_BYTES=16, `length`=40, `out_ready`=1, 3 input words → 3 beats with `out_keep` ffff, ffff, 00ff. `out_last` is set only on beat 3, whose bytes 8..15 are 0. `done` pulses 1 cycle after beat 3; 3 consecutive cycles of `out_valid` with no gaps.
- `length`=16 → 1 beat with `out_keep`=ffff and `out_last`=1. `length`=1 → `out_keep`=0001 and `out_last`=1.
- `length`=0 start → `error_len` pulses 1 cycle, `in_ready` stays 0, `busy` stays 0, no output.
- `length`=1000 with random `out_ready` (50%) and random `in_valid` gaps → 63 beats, data matches the input order, outputs stable during stalls, last beat `out_keep`=00ff, exactly one `out_last`.
- `start` pulsed during RUN with `length`=5 → ignored; the current frame completes with its original length.
- `abort`, then `reset_n` low, mid-frame at beat 2 of 4:
  - on `abort`: next cycle `out_valid`=0, `busy`=0, no `done`;
  - on `reset_n` low: all outputs 0 immediately.
  - A new frame with `length`=32 afterwards → 2 clean beats, `out_last` on beat 2.
